watchdog_scheduler: RTL and testbench
=====================================

# watchdog_scheduler

Sequencing and arbitration front-end for the system watchdog timer in the LPC glue logic. It generates the 125 ms time base, owns the 8-bit watchdog control register, and merges host (LPC) and BMC kick requests into single load pulses. It also forwards interrupt-clear requests and tracks the expired and tripped conditions reported back by the watchdog timer.

## Interface
- CLK_PER_125MS, 4125000: LpcClock cycles per 125 ms strobe period (33 MHz); minimum 2.
- LpcClock  in  1  33 MHz LPC clock; sole clock.
- LpcReset  in  1  synchronous, active-high reset.
- HostWrEn  in  1  one-cycle write strobe to the control register.
- HostWrData  in  8  write data: [3:0] timeout seconds, [4] reset enable, [5] lock, [7:6] ignored.
- HostKick  in  1  one-cycle host reload request.
- BmcKick  in  1  one-cycle BMC reload request.
- BmcKickEn  in  1  level; 0 ignores BmcKick.
- ClearReq  in  3  one-cycle clear requests {watchdog, reset, power}.
- WatchDogIREQ  in  1  expiry interrupt from the watchdog timer.
- WatchDogReset  in  1  reset request from the watchdog timer (sticky).
- Strobe125msec  out  1  one-cycle pulse every CLK_PER_125MS cycles.
- LoadWDTimer  out  1  one-cycle reload pulse to the watchdog timer.
- WatchDogRegister  out  8  control register; [7:6] read 0.
- ClearInterrupt  out  3  registered copy of ClearReq, one cycle.
- SchedState  out  3  current FSM state encoding.
- LoadCount  out  8  saturating count of issued LoadWDTimer pulses.

## Operation
- FSM states: DISABLED(0), ARMING(1), RUNNING(2), EXPIRED(3), TRIPPED(4). Reset state is DISABLED.
- DISABLED: timeout field is 0, and kicks are ignored.
  - A write with [3:0]≠0 goes to ARMING.
- ARMING: issues a single LoadWDTimer, then goes to RUNNING.
- RUNNING: an accepted kick issues LoadWDTimer.
  - WatchDogIREQ=1 goes to EXPIRED.
  - A write with [3:0]=0 goes to DISABLED; a write with a nonzero timeout goes to ARMING.
- EXPIRED: an accepted kick or write reloads the timer and returns to RUNNING.
  - WatchDogReset=1 goes to TRIPPED.
- TRIPPED: terminal until LpcReset. Writes, kicks and loads are all ignored.
- Any state sees WatchDogReset=1: enter TRIPPED; this has priority over everything.
- Lock: once WatchDogRegister[5]=1, host writes are ignored until LpcReset. Kicks still work.
- Accepted kick = HostKick | (BmcKick & BmcKickEn). Simultaneous host and BMC kicks merge into one load.
- A write and a kick in the same cycle: the write wins and exactly one load results (from ARMING).
- A kick during the ARMING cycle is absorbed, with no second load.
- Prescaler:
  - Counts 0..CLK_PER_125MS-1 and wraps.
  - Strobe125msec=1 on the cycle the count equals CLK_PER_125MS-1.
  - The count clears to 0 on every LoadWDTimer cycle, so the first strobe after a load is a full period later.
- LoadCount: increments per LoadWDTimer and saturates at 255. Cleared by any accepted host write.
- ClearInterrupt: passes ClearReq through, registered. Not gated by state.

## Timing
- Reset values:
  - Strobe125msec=0, LoadWDTimer=0, WatchDogRegister=8'h00, ClearInterrupt=3'b000.
  - SchedState=DISABLED, LoadCount=0, prescaler=0.
- Host write sampled at edge N:
  - WatchDogRegister is valid after N+1.
  - LoadWDTimer is high in cycle N+2 (ARMING).
- Accepted kick sampled at edge N (RUNNING/EXPIRED): LoadWDTimer is high in cycle N+1.
- ClearReq at edge N: ClearInterrupt at N+1, for one cycle.
- WatchDogIREQ/WatchDogReset sampled at N: SchedState updates at N+1.
- LoadWDTimer never asserts on two consecutive cycles.
- LpcReset asserted mid-operation: all state returns to reset values at the next edge, including TRIPPED and lock.

## Structure
- Shared package wdt_pkg holds:
  - state encodings;
  - register bit positions (TIMEOUT_MSB=3, EN_BIT=4, LOCK_BIT=5);
  - default CLK_PER_125MS.
- One natural sub-module, wdt_prescaler: the period counter with synchronous clear and strobe output.
- FSM, register, kick merge and counter live in watchdog_scheduler.

## Test plan
All scenarios use CLK_PER_125MS=8.
- Prescaler: after reset with no loads, Strobe125msec pulses at cycles 8, 16, 24. A load at cycle 11 moves the next strobe to cycle 19.
- Arm: write 8'h13 at N → WatchDogRegister=8'h13 at N+1, one LoadWDTimer at N+2, SchedState=RUNNING at N+3.
- Kick merge: HostKick and BmcKick (BmcKickEn=1) at the same edge → exactly one LoadWDTimer, LoadCount+1.
  - With BmcKickEn=0, BmcKick alone → no load.
- Write/kick collision: write 8'h15 plus HostKick at the same edge → a single load at N+2. Lock write 8'h25, then write 8'h00 → register stays 8'h25.
- Expiry: drive WatchDogIREQ → EXPIRED. A HostKick then gives a load and RUNNING. Drive WatchDogReset → TRIPPED, and subsequent kicks and writes produce no LoadWDTimer.
- Reset mid-operation: assert LpcReset while in TRIPPED with lock set → all outputs at reset values the next cycle. Write 8'h02 is then accepted and arms.

Source files
------------

// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the watchdog scheduler slice:
//   - wdt_state_e           : scheduler FSM state encodings (visible on SchedState)
//   - TIMEOUT_MSB/EN_BIT/LOCK_BIT : control register bit positions
//   - CLK_PER_125MS_DEFAULT : LpcClock cycles per 125 ms at 33 MHz
//   - small helpers for the control register and the load counter
// -----------------------------------------------------------------------------
package wdt_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_EXPIRED  = 3'd3,
        ST_TRIPPED  = 3'd4
    } wdt_state_e;

    localparam int TIMEOUT_MSB = 3;
    localparam int EN_BIT      = 4;
    localparam int LOCK_BIT    = 5;

    localparam int CLK_PER_125MS_DEFAULT = 4125000;

    // Writable bits of the control register: timeout, enable, lock. [7:6] read 0.
    localparam logic [7:0] REG_WR_MASK = (8'h01 << LOCK_BIT) | (8'h01 << EN_BIT) | 8'h0F;

    // True when the timeout field of a control register value is nonzero.
    function automatic logic timeout_nonzero(input logic [7:0] reg_val);
        return |reg_val[TIMEOUT_MSB:0];
    endfunction

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : (val + 8'd1);
    endfunction

endpackage

// File: rtl/watchdog_scheduler_if.sv
// -----------------------------------------------------------------------------
// watchdog_scheduler_if
// Host/BMC request bus of the watchdog scheduler.
//   HostWrEn/HostWrData : control register write strobe and data
//   HostKick/BmcKick    : one-cycle reload requests, BmcKickEn gates BmcKick
//   ClearReq            : one-cycle clear requests {watchdog, reset, power}
//   ClearInterrupt      : registered copy of ClearReq returned by the scheduler
// master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface watchdog_scheduler_if;

    logic       HostWrEn;
    logic [7:0] HostWrData;
    logic       HostKick;
    logic       BmcKick;
    logic       BmcKickEn;
    logic [2:0] ClearReq;
    logic [2:0] ClearInterrupt;

    modport master (
        output HostWrEn,
        output HostWrData,
        output HostKick,
        output BmcKick,
        output BmcKickEn,
        output ClearReq,
        input  ClearInterrupt
    );

    modport slave (
        input  HostWrEn,
        input  HostWrData,
        input  HostKick,
        input  BmcKick,
        input  BmcKickEn,
        input  ClearReq,
        output ClearInterrupt
    );

endinterface

// File: rtl/wdt_prescaler.sv
// -----------------------------------------------------------------------------
// wdt_prescaler
// 125 ms time base. Counts 0..PERIOD-1 and wraps; strobe is a registered
// one-cycle pulse aligned with the cycle in which the count equals PERIOD-1.
// Ports:
//   clk    : LpcClock
//   rst    : synchronous active-high reset
//   clr    : synchronous clear (driven by LoadWDTimer), restarts a full period
//   strobe : Strobe125msec
// -----------------------------------------------------------------------------
module wdt_prescaler
    import wdt_pkg::*;
#(
    parameter int PERIOD = CLK_PER_125MS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic strobe
);

    localparam int             CW   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          strobe_d;
    logic          strobe_q;

    // Next count and strobe; the strobe is computed from the next count so the
    // registered pulse lines up with the count value it announces.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        strobe_d = (cnt_d == LAST);
    end

    // Counter and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/watchdog_scheduler.sv
// -----------------------------------------------------------------------------
// watchdog_scheduler
// Sequencing/arbitration front-end of the system watchdog timer.
// Ports:
//   LpcClock, LpcReset : 33 MHz clock, synchronous active-high reset
//   host_bus           : host write, host/BMC kicks, clear requests/acks
//   WatchDogIREQ       : expiry indication from the watchdog timer
//   WatchDogReset      : sticky reset request from the watchdog timer
//   Strobe125msec      : 125 ms time-base pulse
//   LoadWDTimer        : one-cycle reload pulse to the watchdog timer
//   WatchDogRegister   : control register {2'b00, lock, en, timeout[3:0]}
//   SchedState         : FSM state encoding (wdt_state_e)
//   LoadCount          : saturating count of LoadWDTimer pulses
// A host write is registered first and acted on by the FSM one cycle later,
// so the reload it causes coincides with the ARMING state.
// -----------------------------------------------------------------------------
module watchdog_scheduler
    import wdt_pkg::*;
#(
    parameter int CLK_PER_125MS = CLK_PER_125MS_DEFAULT
) (
    input  logic                       LpcClock,
    input  logic                       LpcReset,
    watchdog_scheduler_if.slave        host_bus,
    input  logic                       WatchDogIREQ,
    input  logic                       WatchDogReset,
    output logic                       Strobe125msec,
    output logic                       LoadWDTimer,
    output logic [7:0]                 WatchDogRegister,
    output logic [2:0]                 SchedState,
    output logic [7:0]                 LoadCount
);

    wdt_state_e state_d, state_q;
    logic [7:0] reg_d, reg_q;
    logic       wr_pend_d, wr_pend_q;
    logic       load_d, load_q;
    logic [7:0] cnt_d, cnt_q;
    logic [2:0] clr_d, clr_q;

    logic       wr_acc_s;
    logic       kick_s;
    logic       kick_acc_s;

    // Write/kick acceptance and the register, pending-write, counter and clear datapath.
    always_comb begin
        wr_acc_s = host_bus.HostWrEn & ~reg_q[LOCK_BIT] &
                   (state_q != ST_TRIPPED) & ~WatchDogReset;
        kick_s   = host_bus.HostKick | (host_bus.BmcKick & host_bus.BmcKickEn);
        // A write in flight owns the next load; a kick right after a load is
        // absorbed so reload pulses are never back to back.
        kick_acc_s = kick_s & ~wr_acc_s & ~wr_pend_q & ~load_q;

        reg_d     = reg_q;
        wr_pend_d = wr_acc_s;
        if (wr_acc_s) begin
            reg_d = host_bus.HostWrData & REG_WR_MASK;
        end else begin
            reg_d = reg_q;
        end

        cnt_d = cnt_q;
        if (wr_acc_s) begin
            // Clear, but still count a load issued on this same edge.
            cnt_d = {7'd0, load_d};
        end else if (load_d) begin
            cnt_d = sat_inc8(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end

        clr_d = host_bus.ClearReq;
    end

    // FSM next state and reload request.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        if (WatchDogReset) begin
            state_d = ST_TRIPPED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    if (wr_pend_q && timeout_nonzero(reg_q)) begin
                        state_d = ST_ARMING;
                        load_d  = 1'b1;
                    end else begin
                        state_d = ST_DISABLED;
                    end
                end
                ST_ARMING: begin
                    if (wr_pend_q && !timeout_nonzero(reg_q)) begin
                        state_d = ST_DISABLED;
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_RUNNING, ST_EXPIRED: begin
                    if (wr_pend_q) begin
                        if (timeout_nonzero(reg_q)) begin
                            state_d = ST_ARMING;
                            load_d  = 1'b1;
                        end else begin
                            state_d = ST_DISABLED;
                        end
                    end else if (kick_acc_s) begin
                        state_d = ST_RUNNING;
                        load_d  = 1'b1;
                    end else if (WatchDogIREQ) begin
                        state_d = ST_EXPIRED;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_TRIPPED: begin
                    state_d = ST_TRIPPED;
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge LpcClock) begin
        if (LpcReset) begin
            state_q   <= ST_DISABLED;
            reg_q     <= 8'h00;
            wr_pend_q <= 1'b0;
            load_q    <= 1'b0;
            cnt_q     <= 8'h00;
            clr_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            reg_q     <= reg_d;
            wr_pend_q <= wr_pend_d;
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            clr_q     <= clr_d;
        end
    end

    wdt_prescaler #(
        .PERIOD (CLK_PER_125MS)
    ) u_prescaler (
        .clk    (LpcClock),
        .rst    (LpcReset),
        .clr    (load_q),
        .strobe (Strobe125msec)
    );

    assign LoadWDTimer             = load_q;
    assign WatchDogRegister        = reg_q;
    assign SchedState              = state_q;
    assign LoadCount               = cnt_q;
    assign host_bus.ClearInterrupt = clr_q;

endmodule

// File: tb/tb_watchdog_scheduler.sv
// -----------------------------------------------------------------------------
// tb_watchdog_scheduler
// Directed, table-driven bench for watchdog_scheduler with CLK_PER_125MS=8.
// Inputs change just after the falling edge; outputs are compared at the
// falling edge, half a cycle away from the sampling edge.
// -----------------------------------------------------------------------------
module tb_watchdog_scheduler;

    logic       LpcClock = 1'b0;
    logic       LpcReset = 1'b1;
    logic       WatchDogIREQ = 1'b0;
    logic       WatchDogReset = 1'b0;
    logic       Strobe125msec;
    logic       LoadWDTimer;
    logic [7:0] WatchDogRegister;
    logic [2:0] SchedState;
    logic [7:0] LoadCount;

    int n_checks = 0;
    int n_errors = 0;

    watchdog_scheduler_if bus ();

    watchdog_scheduler #(
        .CLK_PER_125MS (8)
    ) dut (
        .LpcClock         (LpcClock),
        .LpcReset         (LpcReset),
        .host_bus         (bus),
        .WatchDogIREQ     (WatchDogIREQ),
        .WatchDogReset    (WatchDogReset),
        .Strobe125msec    (Strobe125msec),
        .LoadWDTimer      (LoadWDTimer),
        .WatchDogRegister (WatchDogRegister),
        .SchedState       (SchedState),
        .LoadCount        (LoadCount)
    );

    always #5 LpcClock = ~LpcClock;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       hkick;
        logic       bkick;
        logic       bken;
        logic [2:0] clr_req;
        logic       ireq;
        logic       wdrst;
        logic       exp_load;
        logic [7:0] exp_reg;
        logic [2:0] exp_state;
        logic [7:0] exp_cnt;
        logic [2:0] exp_clr;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic wr_en, input logic [7:0] wd,
                                input logic hk, input logic bk, input logic be,
                                input logic [2:0] cr, input logic ir, input logic wr,
                                input logic el, input logic [7:0] er,
                                input logic [2:0] es, input logic [7:0] ec,
                                input logic [2:0] ecl);
        vec_t v;
        v.wr_en = wr_en; v.wr_data = wd; v.hkick = hk; v.bkick = bk; v.bken = be;
        v.clr_req = cr; v.ireq = ir; v.wdrst = wr;
        v.exp_load = el; v.exp_reg = er; v.exp_state = es; v.exp_cnt = ec; v.exp_clr = ecl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge LpcClock);
        @(negedge LpcClock);
    endtask

    task automatic set_idle();
        bus.HostWrEn   = 1'b0;
        bus.HostWrData = 8'h00;
        bus.HostKick   = 1'b0;
        bus.BmcKick    = 1'b0;
        bus.BmcKickEn  = 1'b0;
        bus.ClearReq   = 3'b000;
        WatchDogIREQ   = 1'b0;
        WatchDogReset  = 1'b0;
    endtask

    // Leaves the bench in cycle 1: first cycle after reset release, prescaler count 0.
    task automatic do_reset();
        set_idle();
        LpcReset = 1'b1;
        tick();
        tick();
        LpcReset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " strobe"}, {31'd0, Strobe125msec}, 32'd0);
        check({tag, " load"},   {31'd0, LoadWDTimer}, 32'd0);
        check({tag, " reg"},    {24'd0, WatchDogRegister}, 32'h00);
        check({tag, " clr"},    {29'd0, bus.ClearInterrupt}, 32'd0);
        check({tag, " state"},  {29'd0, SchedState}, 32'd0);
        check({tag, " lcnt"},   {24'd0, LoadCount}, 32'd0);
    endtask

    initial begin
        set_idle();

        // Prescaler free-running: strobes on cycles 8, 16, 24.
        do_reset();
        check_reset_values("reset");
        for (int c = 1; c <= 26; c++) begin
            check($sformatf("pre_free c%0d strobe", c), {31'd0, Strobe125msec},
                  ((c % 8) == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Prescaler with a load at cycle 11 (write during cycle 9): strobes at 8 and 19.
        do_reset();
        for (int c = 1; c <= 22; c++) begin
            check($sformatf("pre_load c%0d strobe", c), {31'd0, Strobe125msec},
                  (c == 8 || c == 19) ? 32'd1 : 32'd0);
            check($sformatf("pre_load c%0d load", c), {31'd0, LoadWDTimer},
                  (c == 11) ? 32'd1 : 32'd0);
            set_idle();
            if (c == 9) begin
                bus.HostWrEn   = 1'b1;
                bus.HostWrData = 8'h13;
            end
            tick();
        end

        // Main sequence: inputs applied for one cycle, outputs expected in the next.
        //                wr    data  hk    bk    be    clr     ir    wdr  | load  reg    st    cnt    clr
        vecs[0]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0, 3'd0);
        vecs[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0, 3'd5);
        vecs[2]  = mk(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'h13, 3'd0, 8'd0, 3'd2);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h13, 3'd1, 8'd1, 3'd0);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h13, 3'd2, 8'd1, 3'd0);
        vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h13, 3'd2, 8'd1, 3'd0);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h13, 3'd2, 8'd2, 3'd0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h13, 3'd2, 8'd2, 3'd0);
        vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h13, 3'd2, 8'd2, 3'd0);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h13, 3'd2, 8'd3, 3'd0);
        vecs[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h13, 3'd2, 8'd3, 3'd0);
        vecs[11] = mk(1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h15, 3'd2, 8'd0, 3'd0);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h15, 3'd1, 8'd1, 3'd0);
        vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h15, 3'd2, 8'd1, 3'd0);
        vecs[14] = mk(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h10, 3'd2, 8'd0, 3'd0);
        vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h10, 3'd0, 8'd0, 3'd0);
        vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h10, 3'd0, 8'd0, 3'd0);
        vecs[17] = mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd0, 8'd0, 3'd0);
        vecs[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h25, 3'd1, 8'd1, 3'd0);
        vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd2, 8'd1, 3'd0);
        vecs[20] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd2, 8'd1, 3'd0);
        vecs[21] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd2, 8'd1, 3'd0);
        vecs[22] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h25, 3'd3, 8'd1, 3'd0);
        vecs[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd3, 8'd1, 3'd0);
        vecs[24] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h25, 3'd2, 8'd2, 3'd0);
        vecs[25] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h25, 3'd3, 8'd2, 3'd0);
        vecs[26] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h25, 3'd4, 8'd2, 3'd0);
        vecs[27] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd4, 8'd2, 3'd0);
        vecs[28] = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd4, 8'd2, 3'd0);
        vecs[29] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h25, 3'd4, 8'd2, 3'd0);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            bus.HostWrEn   = vecs[i].wr_en;
            bus.HostWrData = vecs[i].wr_data;
            bus.HostKick   = vecs[i].hkick;
            bus.BmcKick    = vecs[i].bkick;
            bus.BmcKickEn  = vecs[i].bken;
            bus.ClearReq   = vecs[i].clr_req;
            WatchDogIREQ   = vecs[i].ireq;
            WatchDogReset  = vecs[i].wdrst;
            tick();
            check($sformatf("vec%0d load", i),  {31'd0, LoadWDTimer},       {31'd0, vecs[i].exp_load});
            check($sformatf("vec%0d reg", i),   {24'd0, WatchDogRegister},  {24'd0, vecs[i].exp_reg});
            check($sformatf("vec%0d state", i), {29'd0, SchedState},        {29'd0, vecs[i].exp_state});
            check($sformatf("vec%0d lcnt", i),  {24'd0, LoadCount},         {24'd0, vecs[i].exp_cnt});
            check($sformatf("vec%0d clr", i),   {29'd0, bus.ClearInterrupt}, {29'd0, vecs[i].exp_clr});
        end

        // Reset from TRIPPED with lock set, with competing requests on the same edge.
        set_idle();
        LpcReset     = 1'b1;
        bus.ClearReq = 3'b111;
        bus.HostKick = 1'b1;
        tick();
        check_reset_values("midrst");
        set_idle();
        LpcReset = 1'b0;

        // Lock cleared by reset: a write is accepted again and arms; [7:6] read 0.
        bus.HostWrEn   = 1'b1;
        bus.HostWrData = 8'hC2;
        tick();
        set_idle();
        check("rearm reg",    {24'd0, WatchDogRegister}, 32'h02);
        check("rearm state0", {29'd0, SchedState}, 32'd0);
        tick();
        check("rearm load",   {31'd0, LoadWDTimer}, 32'd1);
        check("rearm state1", {29'd0, SchedState}, 32'd1);
        check("rearm lcnt",   {24'd0, LoadCount}, 32'd1);
        tick();
        check("rearm load2",  {31'd0, LoadWDTimer}, 32'd0);
        check("rearm state2", {29'd0, SchedState}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
